// File: rtl/vga_rect_engine_if.sv
// Command and plot-port bundle for vga_rect_engine.
//   master : command source; drives cmd_*, observes cmd_ready and the plot port
//   slave  : drawing engine; accepts cmd_*, drives cmd_ready, x, y, color, plot, done
interface vga_rect_engine_if #(
   parameter int unsigned X_BITS     = 8,
   parameter int unsigned Y_BITS     = 7,
   parameter int unsigned COLOR_BITS = 3
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_mode;
   logic [X_BITS-1:0]     cmd_x0;
   logic [Y_BITS-1:0]     cmd_y0;
   logic [X_BITS-1:0]     cmd_w;
   logic [Y_BITS-1:0]     cmd_h;
   logic [COLOR_BITS-1:0] cmd_color;
   logic [X_BITS-1:0]     x;
   logic [Y_BITS-1:0]     y;
   logic [COLOR_BITS-1:0] color;
   logic                  plot;
   logic                  done;

   modport master (
      output cmd_valid, cmd_mode, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
      input  cmd_ready, x, y, color, plot, done
   );

   modport slave (
      input  cmd_valid, cmd_mode, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
      output cmd_ready, x, y, color, plot, done
   );
endinterface

// File: rtl/vga_rect_engine.sv
// Raster drawing engine feeding the vga_adapter plot port. Accepts one command
// at a time (pixel / filled rect / outline rect / clear), clips it to the
// screen, and scans the region one position per clock in raster order.
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : cmd_valid/cmd_ready handshake + command fields in,
//                 x, y, color, plot, done out (all registered except cmd_ready)
module vga_rect_engine #(
   parameter int unsigned X_BITS     = 8,
   parameter int unsigned Y_BITS     = 7,
   parameter int unsigned COLOR_BITS = 3,
   parameter int unsigned SCREEN_W   = 160,
   parameter int unsigned SCREEN_H   = 120
) (
   input logic              clk,
   input logic              resetn,
   vga_rect_engine_if.slave bus
);
   localparam int unsigned XE = X_BITS + 1;
   localparam int unsigned YE = Y_BITS + 1;
   localparam logic [XE-1:0] SCR_W = XE'(SCREEN_W);
   localparam logic [YE-1:0] SCR_H = YE'(SCREEN_H);

   localparam logic [1:0] MODE_PIXEL   = 2'd0;
   localparam logic [1:0] MODE_OUTLINE = 2'd2;
   localparam logic [1:0] MODE_CLEAR   = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [X_BITS-1:0]     x_q, x_d, x_org_q, x_org_d;
   logic [Y_BITS-1:0]     y_q, y_d, y_org_q, y_org_d;
   logic [XE-1:0]         x_end_q, x_end_d, x_last_q, x_last_d;
   logic [YE-1:0]         y_end_q, y_end_d, y_last_q, y_last_d;
   logic [COLOR_BITS-1:0] color_q, color_d;
   logic                  plot_q, plot_d;
   logic                  done_q, done_d;
   logic                  outline_q, outline_d;

   // Effective region of the command currently on the bus (extended widths so sums never wrap)
   logic [XE-1:0] acc_x0, acc_w, acc_xsum;
   logic [YE-1:0] acc_y0, acc_h, acc_ysum;
   logic          acc_empty;

   always_comb begin
      acc_x0 = {1'b0, bus.cmd_x0};
      acc_y0 = {1'b0, bus.cmd_y0};
      acc_w  = {1'b0, bus.cmd_w};
      acc_h  = {1'b0, bus.cmd_h};
      if (bus.cmd_mode == MODE_PIXEL) begin
         acc_w = XE'(1);
         acc_h = YE'(1);
      end else if (bus.cmd_mode == MODE_CLEAR) begin
         acc_x0 = '0;
         acc_y0 = '0;
         acc_w  = SCR_W;
         acc_h  = SCR_H;
      end
      acc_xsum  = acc_x0 + acc_w;
      acc_ysum  = acc_y0 + acc_h;
      acc_empty = (acc_w == '0) || (acc_h == '0) || (acc_x0 >= SCR_W) || (acc_y0 >= SCR_H);
   end

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.x         = x_q;
   assign bus.y         = y_q;
   assign bus.color     = color_q;
   assign bus.plot      = plot_q;
   assign bus.done      = done_q;

   // State and output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         x_org_q   <= '0;
         y_org_q   <= '0;
         x_end_q   <= '0;
         y_end_q   <= '0;
         x_last_q  <= '0;
         y_last_q  <= '0;
         color_q   <= '0;
         plot_q    <= 1'b0;
         done_q    <= 1'b0;
         outline_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         x_org_q   <= x_org_d;
         y_org_q   <= y_org_d;
         x_end_q   <= x_end_d;
         y_end_q   <= y_end_d;
         x_last_q  <= x_last_d;
         y_last_q  <= y_last_d;
         color_q   <= color_d;
         plot_q    <= plot_d;
         done_q    <= done_d;
         outline_q <= outline_d;
      end
   end

   // Next-state, scan counters and next plot/done values
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      x_org_d   = x_org_q;
      y_org_d   = y_org_q;
      x_end_d   = x_end_q;
      y_end_d   = y_end_q;
      x_last_d  = x_last_q;
      y_last_d  = y_last_q;
      color_d   = color_q;
      outline_d = outline_q;
      plot_d    = 1'b0;
      done_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               color_d   = bus.cmd_color;
               outline_d = (bus.cmd_mode == MODE_OUTLINE);
               x_org_d   = acc_x0[X_BITS-1:0];
               y_org_d   = acc_y0[Y_BITS-1:0];
               x_end_d   = (acc_xsum < SCR_W) ? acc_xsum : SCR_W;
               y_end_d   = (acc_ysum < SCR_H) ? acc_ysum : SCR_H;
               // Unclipped far edges; only meaningful for a non-empty region
               x_last_d  = acc_xsum - XE'(1);
               y_last_d  = acc_ysum - YE'(1);
               if (acc_empty) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_DRAW;
                  x_d     = acc_x0[X_BITS-1:0];
                  y_d     = acc_y0[Y_BITS-1:0];
                  // Origin is the top-left corner, on an edge in every mode
                  plot_d  = 1'b1;
               end
            end
         end
         S_DRAW: begin
            if (({1'b0, x_q} + XE'(1)) == x_end_q) begin
               if (({1'b0, y_q} + YE'(1)) == y_end_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  x_d = x_org_q;
                  y_d = y_q + Y_BITS'(1);
               end
            end else begin
               x_d = x_q + X_BITS'(1);
            end
            if (state_d == S_DRAW) begin
               plot_d = !outline_q
                        || (x_d == x_org_q) || ({1'b0, x_d} == x_last_q)
                        || (y_d == y_org_q) || ({1'b0, y_d} == y_last_q);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end
endmodule
